// File: rtl/game_pkg.sv
// Shared definitions for the sequence generator: FSM state encoding and LFSR helpers.
// Pure declarations; no latency or backpressure of its own.
package game_pkg;
    localparam int LFSR_W    = 16;
    localparam int SYM_W_DEF = 3;
    localparam logic [LFSR_W-1:0] LFSR_NONZERO = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_SHOW,
        ST_DONE
    } seq_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_fix(input logic [LFSR_W-1:0] v);
        return (v == '0) ? LFSR_NONZERO : v;
    endfunction

    // Fibonacci x^16+x^14+x^13+x^11+1, never allowed to lock up at zero.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return lfsr_fix({v[14:0], fb});
    endfunction
endpackage

// File: rtl/seq_lfsr.sv
// Free-running 16-bit LFSR, advances every clock; exposes its low OUT_W bits.
// Latency: value changes every edge; no backpressure.
module seq_lfsr
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = SYM_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [OUT_W-1:0] o_bits
);
    localparam logic [LFSR_W-1:0] SEED_FIX = lfsr_fix(SEED);

    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED_FIX;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_bits = r_lfsr[OUT_W-1:0];
endmodule

// File: rtl/sequence_generator.sv
// Builds and displays a random symbol sequence, then serves questions from it.
// Latency: sequence_done 1+SEQ_LEN+SEQ_LEN*SHOW_CYCLES edges after request_seq, rand_Q 1 edge; no backpressure.
module sequence_generator
    import game_pkg::*;
#(
    parameter int          SEQ_LEN     = 5,
    parameter int          SYM_W       = SYM_W_DEF,
    parameter int          SHOW_CYCLES = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             request_seq,
    input  logic             request_Q,
    output logic             sequence_done,
    output logic [SYM_W-1:0] rand_Q,
    output logic [2:0]       q_idx,
    output logic             q_err,
    output logic [SYM_W-1:0] seq_sym,
    output logic             seq_sym_valid,
    output logic [2:0]       seq_idx,
    output logic             busy
);
    localparam int               CNT_W    = $clog2(SHOW_CYCLES + 1);
    localparam logic [2:0]       LAST_IDX = 3'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHOW_CYCLES - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [SYM_W-1:0] r_buf [SEQ_LEN];
    logic [2:0]       r_wr_idx;
    logic [2:0]       r_seq_idx;
    logic [CNT_W-1:0] r_show_cnt;
    logic             r_seq_valid;
    logic             r_busy;
    logic             r_sym_vld;
    logic             r_done;
    logic [2:0]       r_pick;
    logic [SYM_W-1:0] r_rand_q;
    logic [2:0]       r_q_idx;
    logic             r_q_err;
    logic [SYM_W-1:0] w_lfsr;
    logic             w_gen_start;
    logic             w_gen_wr;
    logic             w_show_start;
    logic             w_show_tick;
    logic             w_sym_adv;
    logic             w_show_end;
    logic             w_abort;

    seq_lfsr #(
        .SEED  (SEED),
        .OUT_W (SYM_W)
    ) u_lfsr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .o_bits  (w_lfsr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gen_start  = 1'b0;
        w_gen_wr     = 1'b0;
        w_show_start = 1'b0;
        w_show_tick  = 1'b0;
        w_sym_adv    = 1'b0;
        w_show_end   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (request_seq) begin
                    w_state_nxt = ST_GEN;
                    w_gen_start = 1'b1;
                end
            end
            ST_GEN: begin
                if (!request_seq) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_gen_wr = 1'b1;
                    if (r_wr_idx == LAST_IDX) begin
                        w_state_nxt  = ST_SHOW;
                        w_show_start = 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                if (!request_seq) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_show_tick = 1'b1;
                    if (r_show_cnt == LAST_CNT) begin
                        if (r_seq_idx == LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                            w_show_end  = 1'b1;
                        end else begin
                            w_sym_adv = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!request_seq) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_idx    <= '0;
            r_seq_idx   <= '0;
            r_show_cnt  <= '0;
            r_seq_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sym_vld   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Registered so the done level follows one edge behind the DONE state.
            r_done <= (r_state == ST_DONE) && request_seq;
            if (w_gen_start) begin
                r_seq_valid <= 1'b0;
                r_wr_idx    <= '0;
                r_busy      <= 1'b1;
            end
            if (w_gen_wr) begin
                r_wr_idx <= r_wr_idx + 3'd1;
            end
            if (w_show_start) begin
                r_seq_idx  <= '0;
                r_show_cnt <= '0;
                r_sym_vld  <= 1'b1;
            end
            if (w_show_tick) begin
                r_show_cnt <= (r_show_cnt == LAST_CNT) ? '0 : r_show_cnt + CNT_W'(1);
            end
            if (w_sym_adv) begin
                r_seq_idx <= r_seq_idx + 3'd1;
            end
            if (w_show_end || w_abort) begin
                r_busy     <= 1'b0;
                r_sym_vld  <= 1'b0;
                r_seq_idx  <= '0;
                r_show_cnt <= '0;
            end
            if (w_show_end) begin
                r_seq_valid <= 1'b1;
            end
            if (w_abort) begin
                r_seq_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_gen_wr) begin
            r_buf[r_wr_idx] <= w_lfsr;
        end
    end

    // Question path ignores the FSM; it only trusts the buffer once seq_valid is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pick   <= '0;
            r_rand_q <= '0;
            r_q_idx  <= '0;
            r_q_err  <= 1'b0;
        end else begin
            r_pick  <= (r_pick == LAST_IDX) ? 3'd0 : r_pick + 3'd1;
            r_q_err <= request_Q && !r_seq_valid;
            if (request_Q) begin
                if (r_seq_valid) begin
                    r_rand_q <= r_buf[r_pick];
                    r_q_idx  <= r_pick;
                end else begin
                    r_rand_q <= '0;
                    r_q_idx  <= '0;
                end
            end
        end
    end

    assign sequence_done = r_done;
    assign rand_Q        = r_rand_q;
    assign q_idx         = r_q_idx;
    assign q_err         = r_q_err;
    assign seq_sym       = r_sym_vld ? r_buf[r_seq_idx] : '0;
    assign seq_sym_valid = r_sym_vld;
    assign seq_idx       = r_seq_idx;
    assign busy          = r_busy;
endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator with default parameters.
module tb_sequence_generator;
    localparam int SEQ_LEN  = 5;
    localparam int SHOW     = 4;
    localparam int GEN_END  = SEQ_LEN;
    localparam int SHOW_END = SEQ_LEN + SEQ_LEN * SHOW;
    localparam int DONE_N   = SHOW_END + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       request_seq = 1'b0;
    logic       request_Q = 1'b0;
    logic       sequence_done, q_err, seq_sym_valid, busy;
    logic [2:0] rand_Q, q_idx, seq_sym, seq_idx;

    sequence_generator #(
        .SEQ_LEN     (SEQ_LEN),
        .SYM_W       (3),
        .SHOW_CYCLES (SHOW),
        .SEED        (16'hACE1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request_seq   (request_seq),
        .request_Q     (request_Q),
        .sequence_done (sequence_done),
        .rand_Q        (rand_Q),
        .q_idx         (q_idx),
        .q_err         (q_err),
        .seq_sym       (seq_sym),
        .seq_sym_valid (seq_sym_valid),
        .seq_idx       (seq_idx),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sym;
        logic [2:0] idx;
        logic       err;
    } q_exp_t;

    q_exp_t      q_sb[$];
    logic [2:0]  sym_sb[$];
    logic [15:0] m_lfsr;
    int          m_pick;
    logic [2:0]  m_buf [SEQ_LEN];
    bit          m_seq_valid = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] n;
        n = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return (n == 16'h0) ? 16'h0001 : n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
            m_pick <= 0;
        end else begin
            m_lfsr <= ref_step(m_lfsr);
            m_pick <= (m_pick == SEQ_LEN - 1) ? 0 : m_pick + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raises request_Q for the next edge and records what that edge must return.
    task automatic drive_q_edge;
        request_Q = 1'b1;
        if (m_seq_valid) q_sb.push_back('{m_buf[m_pick], 3'(m_pick), 1'b0});
        else             q_sb.push_back('{3'd0, 3'd0, 1'b1});
        tick;
    endtask

    task automatic test_reset;
        logic [15:0] outs;
        #2 rst = 1'b0;
        #1;
        outs = {sequence_done, rand_Q, q_idx, q_err, seq_sym, seq_sym_valid, seq_idx, busy};
        n_tests++;
        if (outs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_async outputs got %h want 0000", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        tick;
        outs = {sequence_done, rand_Q, q_idx, q_err, seq_sym, seq_sym_valid, seq_idx, busy};
        n_tests++;
        if (outs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_idle outputs got %h want 0000", outs);
        end
        for (int i = 0; i < 100; i++) begin
            n_tests++;
            if (dut.u_lfsr.r_lfsr !== m_lfsr || dut.u_lfsr.r_lfsr == 16'h0) begin
                n_fail++;
                $display("FAIL lfsr cycle %0d got %h want %h (nonzero)", i, dut.u_lfsr.r_lfsr, m_lfsr);
            end
            tick;
        end
    endtask

    task automatic test_no_seq_error;
        q_exp_t e;
        drive_q_edge;
        request_Q = 1'b0;
        e = q_sb.pop_front();
        n_tests++;
        if ({rand_Q, q_idx, q_err} !== e) begin
            n_fail++;
            $display("FAIL noseq_q got sym=%0d idx=%0d err=%b want %0d/%0d/%b", rand_Q, q_idx, q_err, e.sym, e.idx, e.err);
        end
        tick;
        n_tests++;
        if (q_err !== 1'b0 || rand_Q !== 3'd0) begin
            n_fail++;
            $display("FAIL noseq_pulse got err=%b sym=%0d want 0/0", q_err, rand_Q);
        end
    endtask

    // Starts a sequence and checks every cycle up to stop_n edges after the starting edge.
    task automatic test_sequence(input int stop_n, input bit with_q);
        q_exp_t     e;
        logic       ex_busy, ex_vld, ex_done;
        logic [2:0] ex_idx, ex_sym;
        request_seq = 1'b1;
        if (with_q) drive_q_edge;
        else        tick;
        request_Q = 1'b0;
        if (with_q) begin
            e = q_sb.pop_front();
            n_tests++;
            if ({rand_Q, q_idx, q_err} !== e) begin
                n_fail++;
                $display("FAIL gen_start_q got sym=%0d idx=%0d err=%b want %0d/%0d/%b", rand_Q, q_idx, q_err, e.sym, e.idx, e.err);
            end
        end
        m_seq_valid = 1'b0;
        sym_sb.delete();
        for (int n = 0; n <= stop_n; n++) begin
            ex_busy = (n < SHOW_END);
            ex_vld  = (n >= GEN_END) && (n < SHOW_END);
            ex_done = (n >= DONE_N);
            ex_idx  = ex_vld ? 3'((n - GEN_END) / SHOW) : 3'd0;
            ex_sym  = ex_vld ? sym_sb[0] : 3'd0;
            n_tests++;
            if ({busy, seq_sym_valid, sequence_done, seq_idx, seq_sym} !== {ex_busy, ex_vld, ex_done, ex_idx, ex_sym}) begin
                n_fail++;
                $display("FAIL seq edge %0d busy/vld/done/idx/sym got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                         n, busy, seq_sym_valid, sequence_done, seq_idx, seq_sym, ex_busy, ex_vld, ex_done, ex_idx, ex_sym);
            end
            if (ex_vld && ((n - GEN_END) % SHOW == SHOW - 1)) void'(sym_sb.pop_front());
            if (n < SEQ_LEN) begin
                sym_sb.push_back(m_lfsr[2:0]);
                m_buf[n] = m_lfsr[2:0];
            end
            if (n < stop_n) tick;
        end
        if (stop_n >= DONE_N) m_seq_valid = 1'b1;
    endtask

    task automatic test_question;
        q_exp_t e;
        int     gap, nb;
        request_seq = 1'b0;
        drive_q_edge;
        request_Q = 1'b0;
        e = q_sb.pop_front();
        n_tests++;
        if ({rand_Q, q_idx, q_err, sequence_done, busy} !== {e, 2'b00}) begin
            n_fail++;
            $display("FAIL done_q got sym=%0d idx=%0d err=%b done=%b busy=%b want %0d/%0d/%b/0/0",
                     rand_Q, q_idx, q_err, sequence_done, busy, e.sym, e.idx, e.err);
        end
        for (int i = 0; i < 50; i++) begin
            tick;
            n_tests++;
            if ({rand_Q, q_idx, q_err} !== {e.sym, e.idx, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_q cycle %0d got sym=%0d idx=%0d err=%b want %0d/%0d/0", i, rand_Q, q_idx, q_err, e.sym, e.idx);
            end
        end
        for (int k = 0; k < 6; k++) begin
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) tick;
            nb = (k == 2) ? 3 : 1;
            for (int b = 0; b < nb; b++) begin
                drive_q_edge;
                if (b == nb - 1) request_Q = 1'b0;
                e = q_sb.pop_front();
                n_tests++;
                if ({rand_Q, q_idx, q_err} !== e) begin
                    n_fail++;
                    $display("FAIL question %0d.%0d got sym=%0d idx=%0d err=%b want %0d/%0d/%b",
                             k, b, rand_Q, q_idx, q_err, e.sym, e.idx, e.err);
                end
            end
        end
    endtask

    task automatic test_abort;
        q_exp_t e;
        test_sequence(GEN_END + 2 * SHOW, 1'b1);
        request_seq = 1'b0;
        tick;
        n_tests++;
        if ({busy, seq_sym_valid, seq_sym, sequence_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort got busy=%b vld=%b sym=%0d done=%b want 0/0/0/0", busy, seq_sym_valid, seq_sym, sequence_done);
        end
        drive_q_edge;
        request_Q = 1'b0;
        e = q_sb.pop_front();
        n_tests++;
        if ({rand_Q, q_idx, q_err, busy} !== {e, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_q got sym=%0d idx=%0d err=%b busy=%b want %0d/%0d/%b/0", rand_Q, q_idx, q_err, busy, e.sym, e.idx, e.err);
        end
        tick;
        n_tests++;
        if (q_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse got err=%b want 0", q_err);
        end
    endtask

    task automatic test_reset_mid_gen;
        logic [15:0] outs;
        request_seq = 1'b1;
        tick;
        tick;
        tick;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midgen_busy got %b want 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        outs = {sequence_done, rand_Q, q_idx, q_err, seq_sym, seq_sym_valid, seq_idx, busy};
        n_tests++;
        if (outs !== 16'h0) begin
            n_fail++;
            $display("FAIL midgen_reset outputs got %h want 0000", outs);
        end
        m_seq_valid = 1'b0;
        request_seq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick;
        test_sequence(DONE_N, 1'b0);
        test_question();
    endtask

    initial begin
        test_reset();
        test_no_seq_error();
        test_sequence(DONE_N, 1'b0);
        test_question();
        test_reset_mid_gen();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
